xillybus_rd32_arbiter: RTL and testbench

//  Shares the host-bound user_r_read_32 Xillybus stream between NUM_SRC on-board FIFO sources.

---
 rtl/xillybus_rd32_arbiter.sv | 179 +++++++++++++++++
 tb/tb_xillybus_rd32_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xillybus_rd32_arbiter.sv
// Round-robin arbiter that merges NUM_SRC FWFT source FIFOs into the 32-bit Xillybus read stream.
// Each grant is framed by a header word {A5, source, length} so the host can demultiplex the stream.

module xillybus_rd32_lane #(
  parameter int CNTW      = 10,
  parameter int MAX_BURST = 64
) (
  input  logic [CNTW-1:0] cnt_i,
  input  logic            empty_i,
  output logic            elig_o,
  output logic [15:0]     len_o
);
  localparam logic [31:0] MAXB = 32'(MAX_BURST);

  assign elig_o = (cnt_i != '0) && !empty_i;
  assign len_o  = (32'(cnt_i) > MAXB) ? MAXB[15:0] : 16'(cnt_i);
endmodule

module xillybus_rd32_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int CNTW      = 10,
  parameter int MAX_BURST = 64
) (
  input  logic                          bus_clk,
  input  logic                          pcie_perstn,
  input  logic [NUM_SRC-1:0][31:0]      src_data,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC-1:0][CNTW-1:0]  src_count,
  output logic [NUM_SRC-1:0]            src_rden,
  input  logic                          user_r_read_32_rden,
  output logic [31:0]                   user_r_read_32_data,
  output logic                          user_r_read_32_empty,
  output logic                          user_r_read_32_eof,
  input  logic                          user_r_read_32_open
);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  // Per-source eligibility and clamped burst length
  logic [NUM_SRC-1:0]       elig;
  logic [NUM_SRC-1:0][15:0] lane_len;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    xillybus_rd32_lane #(.CNTW(CNTW), .MAX_BURST(MAX_BURST)) u_lane (
      .cnt_i   (src_count[i]),
      .empty_i (src_empty[i]),
      .elig_o  (elig[i]),
      .len_o   (lane_len[i])
    );
  end

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] g_q, g_d;
  logic [SW-1:0] last_q, last_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   rem_q, rem_d;

  logic [3:0][31:0] mem_q;
  logic [1:0]       wp_q, rp_q;
  logic [2:0]       cnt_q;
  logic [31:0]      dout_q;

  logic        full, pop, push;
  logic [31:0] push_data;
  logic        any_elig;
  logic [SW-1:0] pick;
  int          idx;

  assign full = (cnt_q == 3'd4);
  assign pop  = user_r_read_32_open && user_r_read_32_rden && (cnt_q != 3'd0);

  assign user_r_read_32_data  = dout_q;
  assign user_r_read_32_empty = (cnt_q == 3'd0);
  assign user_r_read_32_eof   = 1'b0;

  // Scan from farthest to nearest so the last hit is the first eligible after last_q.
  always_comb begin
    any_elig = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_SRC;
      if (elig[idx]) begin
        pick     = SW'(idx);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    last_d    = last_q;
    len_d     = len_q;
    rem_d     = rem_q;
    push      = 1'b0;
    push_data = '0;
    src_rden  = '0;
    if (!user_r_read_32_open) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_elig) begin
            g_d     = pick;
            len_d   = lane_len[pick];
            state_d = S_HDR;
          end
        end
        S_HDR: begin
          if (!full) begin
            push      = 1'b1;
            push_data = {8'hA5, 8'(g_q), len_q};
            rem_d     = len_q;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          // len is committed: a drained source stalls the burst rather than ending it
          if (!full && !src_empty[g_q]) begin
            src_rden[g_q] = 1'b1;
            push          = 1'b1;
            push_data     = src_data[g_q];
            rem_d         = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              last_d  = g_q;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge pcie_perstn) begin
    if (!pcie_perstn) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      last_q  <= SW'(NUM_SRC - 1);
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
    end
  end

  // Output FIFO: closing the file drops everything buffered, but keeps the last read word.
  always_ff @(posedge bus_clk or negedge pcie_perstn) begin
    if (!pcie_perstn) begin
      mem_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else if (!user_r_read_32_open) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= push_data;
        wp_q        <= wp_q + 2'd1;
      end
      if (pop) begin
        dout_q <= mem_q[rp_q];
        rp_q   <= rp_q + 2'd1;
      end
      cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
    end
  end
endmodule

// File: tb/tb_xillybus_rd32_arbiter.sv
// Bench for xillybus_rd32_arbiter: FWFT source queues feed the DUT, and a grant-level
// round-robin model predicts the exact word stream the core should read.
module tb_xillybus_rd32_arbiter;
  localparam int NUM_SRC   = 4;
  localparam int CNTW      = 10;
  localparam int MAX_BURST = 64;

  logic                         bus_clk;
  logic                         pcie_perstn;
  logic [NUM_SRC-1:0][31:0]     src_data;
  logic [NUM_SRC-1:0]           src_empty;
  logic [NUM_SRC-1:0][CNTW-1:0] src_count;
  logic [NUM_SRC-1:0]           src_rden;
  logic                         user_r_read_32_rden;
  logic [31:0]                  user_r_read_32_data;
  logic                         user_r_read_32_empty;
  logic                         user_r_read_32_eof;
  logic                         user_r_read_32_open;

  xillybus_rd32_arbiter #(.NUM_SRC(NUM_SRC), .CNTW(CNTW), .MAX_BURST(MAX_BURST)) dut (
    .bus_clk              (bus_clk),
    .pcie_perstn          (pcie_perstn),
    .src_data             (src_data),
    .src_empty            (src_empty),
    .src_count            (src_count),
    .src_rden             (src_rden),
    .user_r_read_32_rden  (user_r_read_32_rden),
    .user_r_read_32_data  (user_r_read_32_data),
    .user_r_read_32_empty (user_r_read_32_empty),
    .user_r_read_32_eof   (user_r_read_32_eof),
    .user_r_read_32_open  (user_r_read_32_open)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  int          total, bad;
  logic [31:0] sq [NUM_SRC][$];
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  bit          pend;
  int          popcnt [NUM_SRC];
  int          rd_pct;
  int          m_last;

  function automatic int popsum();
    int s = 0;
    for (int i = 0; i < NUM_SRC; i++) s += popcnt[i];
    return s;
  endfunction

  // Grant-level model: round robin after 'last', header then min(count, MAX_BURST) words.
  task automatic build_exp(inout int last);
    logic [31:0] mq [NUM_SRC][$];
    int left, g, n;
    exp_q.delete();
    left = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      mq[i] = sq[i];
      left += mq[i].size();
    end
    while (left > 0) begin
      g = last;
      do g = (g + 1) % NUM_SRC; while (mq[g].size() == 0);
      n = (mq[g].size() < MAX_BURST) ? mq[g].size() : MAX_BURST;
      exp_q.push_back({8'hA5, 8'(g), 16'(n)});
      for (int k = 0; k < n; k++) exp_q.push_back(mq[g].pop_front());
      left -= n;
      last = g;
    end
  endtask

  // One clock: observe at negedge, apply source pops and new drive after posedge.
  task automatic tick();
    logic [NUM_SRC-1:0] rd_s;
    bit pop_s;
    @(negedge bus_clk);
    if (pend) got.push_back(user_r_read_32_data);
    pend  = 0;
    rd_s  = src_rden;
    pop_s = user_r_read_32_rden && !user_r_read_32_empty && user_r_read_32_open;
    if (pcie_perstn) begin
      total++;
      if (!$onehot0(rd_s) || (rd_s & src_empty) != '0 || (!user_r_read_32_open && rd_s != '0)) begin
        bad++;
        $display("FAIL src_rden_rules t=%0t rden=%b, need one-hot/zero, clear of empty=%b, zero when open=%b",
                 $time, rd_s, src_empty, user_r_read_32_open);
      end
    end
    @(posedge bus_clk);
    #1;
    if (pcie_perstn) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (rd_s[i] && sq[i].size() > 0) begin
          void'(sq[i].pop_front());
          popcnt[i]++;
        end
      pend = pop_s;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i]  = (sq[i].size() != 0) ? sq[i][0] : 32'h0;
      src_empty[i] = (sq[i].size() == 0);
      src_count[i] = CNTW'(sq[i].size());
    end
    user_r_read_32_rden = (int'($urandom_range(99)) < rd_pct);
  endtask

  task automatic wait_got(input int n, input int budget, output bit to);
    int cyc = 0;
    while (got.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    to = (got.size() < n);
  endtask

  task automatic reset_dut();
    pcie_perstn         = 1'b0;
    user_r_read_32_open = 1'b0;
    user_r_read_32_rden = 1'b0;
    rd_pct              = 0;
    repeat (3) tick();
    got.delete();
    pend = 0;
    for (int i = 0; i < NUM_SRC; i++) popcnt[i] = 0;
    m_last      = NUM_SRC - 1;
    pcie_perstn = 1'b1;
  endtask

  task automatic test_reset();
    pcie_perstn = 1'b0;
    repeat (2) tick();
    total += 4;
    if (src_rden !== '0) begin bad++; $display("FAIL reset_rden got=%b need=0", src_rden); end
    if (user_r_read_32_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h need=0", user_r_read_32_data); end
    if (user_r_read_32_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b need=1", user_r_read_32_empty); end
    if (user_r_read_32_eof !== 1'b0) begin bad++; $display("FAIL reset_eof got=%b need=0", user_r_read_32_eof); end
  endtask

  task automatic test_single();
    bit to;
    reset_dut();
    sq[0].push_back(32'h11); sq[0].push_back(32'h22); sq[0].push_back(32'h33);
    build_exp(m_last);
    user_r_read_32_open = 1'b1;
    rd_pct = 100;
    wait_got(exp_q.size(), 200, to);
    repeat (8) tick();
    total++;
    if (to || got.size() != 4) begin bad++; $display("FAIL single_len got=%0d words need=4", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL single_word[%0d] got=%h need=%h", i, got[i], exp_q[i]); end
    end
    total++;
    if (got.size() > 0 && got[0] !== 32'hA500_0003) begin bad++; $display("FAIL single_hdr got=%h need=a5000003", got[0]); end
    total++;
    if (popcnt[0] != 3) begin bad++; $display("FAIL single_pops got=%0d need=3", popcnt[0]); end
  endtask

  task automatic test_round_robin();
    bit to;
    reset_dut();
    for (int s = 0; s < 3; s++) repeat (2) sq[s].push_back($urandom());
    build_exp(m_last);
    user_r_read_32_open = 1'b1;
    rd_pct = 75;
    wait_got(exp_q.size(), 400, to);
    repeat (8) tick();
    total++;
    if (to || got.size() != exp_q.size()) begin bad++; $display("FAIL rr_len got=%0d need=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rr_word[%0d] got=%h need=%h", i, got[i], exp_q[i]); end
    end
    if (got.size() >= 7) begin
      total += 3;
      if (got[0] !== 32'hA500_0002) begin bad++; $display("FAIL rr_hdr0 got=%h need=a5000002", got[0]); end
      if (got[3] !== 32'hA501_0002) begin bad++; $display("FAIL rr_hdr1 got=%h need=a5010002", got[3]); end
      if (got[6] !== 32'hA502_0002) begin bad++; $display("FAIL rr_hdr2 got=%h need=a5020002", got[6]); end
    end
  endtask

  task automatic test_max_burst();
    bit to;
    reset_dut();
    repeat (200) sq[1].push_back($urandom());
    build_exp(m_last);
    user_r_read_32_open = 1'b1;
    rd_pct = 80;
    wait_got(exp_q.size(), 1500, to);
    repeat (8) tick();
    total++;
    if (to || got.size() != 204) begin bad++; $display("FAIL burst_len got=%0d need=204", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL burst_word[%0d] got=%h need=%h", i, got[i], exp_q[i]); end
    end
    if (got.size() >= 196) begin
      total += 4;
      if (got[0]   !== 32'hA501_0040) begin bad++; $display("FAIL burst_hdr0 got=%h need=a5010040", got[0]); end
      if (got[65]  !== 32'hA501_0040) begin bad++; $display("FAIL burst_hdr1 got=%h need=a5010040", got[65]); end
      if (got[130] !== 32'hA501_0040) begin bad++; $display("FAIL burst_hdr2 got=%h need=a5010040", got[130]); end
      if (got[195] !== 32'hA501_0008) begin bad++; $display("FAIL burst_hdr3 got=%h need=a5010008", got[195]); end
    end
  endtask

  task automatic test_stall();
    bit to;
    int buffered;
    reset_dut();
    repeat (30) sq[3].push_back($urandom());
    build_exp(m_last);
    user_r_read_32_open = 1'b1;
    rd_pct = 100;
    wait_got(3, 100, to);
    rd_pct = 0;
    user_r_read_32_rden = 1'b0;
    repeat (20) tick();
    buffered = 1 + popsum() - got.size();
    total += 2;
    if (user_r_read_32_empty !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b need=0", user_r_read_32_empty); end
    if (buffered != 4) begin bad++; $display("FAIL stall_buffered got=%0d need=4", buffered); end
    rd_pct = 70;
    wait_got(exp_q.size(), 400, to);
    repeat (8) tick();
    total++;
    if (to || got.size() != exp_q.size()) begin bad++; $display("FAIL stall_len got=%0d need=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL stall_word[%0d] got=%h need=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_close();
    bit to;
    int last0;
    reset_dut();
    repeat (40) sq[2].push_back($urandom());
    last0 = m_last;
    build_exp(m_last);
    user_r_read_32_open = 1'b1;
    rd_pct = 100;
    wait_got(4, 100, to);
    user_r_read_32_open = 1'b0;
    user_r_read_32_rden = 1'b0;
    rd_pct = 0;
    #2;
    total++;
    if (src_rden !== '0) begin bad++; $display("FAIL close_rden got=%b need=0", src_rden); end
    tick();
    total++;
    if (user_r_read_32_empty !== 1'b1) begin bad++; $display("FAIL close_empty got=%b need=1", user_r_read_32_empty); end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL close_prefix[%0d] got=%h need=%h", i, got[i], exp_q[i]); end
    end
    repeat (3) tick();
    got.delete();
    pend = 0;
    m_last = last0;
    build_exp(m_last);
    user_r_read_32_open = 1'b1;
    rd_pct = 90;
    wait_got(exp_q.size(), 300, to);
    repeat (8) tick();
    total++;
    if (to || got.size() != exp_q.size()) begin bad++; $display("FAIL reopen_len got=%0d need=%0d", got.size(), exp_q.size()); end
    if (got.size() > 0) begin
      total++;
      if (got[0][31:24] !== 8'hA5) begin bad++; $display("FAIL reopen_hdr got=%h need=a5xxxxxx", got[0]); end
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL reopen_word[%0d] got=%h need=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    bit to;
    reset_dut();
    repeat (30) sq[1].push_back($urandom());
    repeat (5) sq[3].push_back($urandom());
    user_r_read_32_open = 1'b1;
    rd_pct = 100;
    wait_got(5, 100, to);
    #3;
    pcie_perstn = 1'b0;
    #1;
    total += 4;
    if (src_rden !== '0) begin bad++; $display("FAIL areset_rden got=%b need=0", src_rden); end
    if (user_r_read_32_empty !== 1'b1) begin bad++; $display("FAIL areset_empty got=%b need=1", user_r_read_32_empty); end
    if (user_r_read_32_data !== 32'h0) begin bad++; $display("FAIL areset_data got=%h need=0", user_r_read_32_data); end
    if (user_r_read_32_eof !== 1'b0) begin bad++; $display("FAIL areset_eof got=%b need=0", user_r_read_32_eof); end
    user_r_read_32_rden = 1'b0;
    rd_pct = 0;
    repeat (4) sq[0].push_back($urandom());
    repeat (2) tick();
    got.delete();
    pend = 0;
    m_last = NUM_SRC - 1;
    build_exp(m_last);
    pcie_perstn = 1'b1;
    rd_pct = 100;
    wait_got(exp_q.size(), 400, to);
    repeat (8) tick();
    total++;
    if (to || got.size() != exp_q.size()) begin bad++; $display("FAIL areset_len got=%0d need=%0d", got.size(), exp_q.size()); end
    if (got.size() > 0) begin
      total++;
      if (got[0] !== 32'hA500_0004) begin bad++; $display("FAIL areset_first_grant got=%h need=a5000004", got[0]); end
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL areset_word[%0d] got=%h need=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    int n, words;
    reset_dut();
    user_r_read_32_open = 1'b1;
    for (int r = 0; r < 4; r++) begin
      got.delete();
      words = 0;
      for (int s = 0; s < NUM_SRC; s++) begin
        n = int'($urandom_range(150));
        repeat (n) sq[s].push_back($urandom());
        words += n;
      end
      if (words == 0) begin sq[r % NUM_SRC].push_back($urandom()); words = 1; end
      build_exp(m_last);
      rd_pct = int'($urandom_range(100, 30));
      wait_got(exp_q.size(), 4 * words + 300, to);
      repeat (8) tick();
      total++;
      if (to || got.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_len got=%0d need=%0d", r, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        total++;
        if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_word[%0d] got=%h need=%h", r, i, got[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pend  = 0;
    rd_pct = 0;
    m_last = NUM_SRC - 1;
    for (int i = 0; i < NUM_SRC; i++) popcnt[i] = 0;
    pcie_perstn         = 1'b0;
    src_data            = '0;
    src_empty           = '1;
    src_count           = '0;
    user_r_read_32_rden = 1'b0;
    user_r_read_32_open = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_stall();
    test_close();
    test_async_reset();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
